// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported byte-addressed SRAM between the
// instruction-fetch port (read-only) and the data-memory port (read/write).
// DM has fixed priority; IF is forced through after MAX_WAIT consecutive
// denied cycles. Read data is registered, giving a one-cycle response.
module sram_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,

    input  logic        dm_req,
    input  logic [3:0]  dm_we,
    input  logic [15:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic [31:0] dm_rdata,
    output logic        dm_rvalid,
    output logic        dm_err,

    output logic [3:0]  sram_w_en,
    output logic [15:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt;
    logic          force_if;
    logic          dm_we_legal;
    logic          dm_read;

    // Grant decision: DM wins unless IF has waited MAX_WAIT cycles.
    always_comb begin
        force_if = (wait_cnt == WAIT_LIMIT);
        dm_gnt   = dm_req & ~rst & ~(if_req & force_if);
        if_gnt   = if_req & ~rst & ~dm_gnt;
    end

    // Strobe classification: only byte, half, word writes or a plain read.
    always_comb begin
        dm_we_legal = (dm_we == 4'b0000) || (dm_we == 4'b0001) ||
                      (dm_we == 4'b0011) || (dm_we == 4'b1111);
        dm_read     = (dm_we == 4'b0000);
    end

    // SRAM port mux; idle drives zeros so the SRAM sees a quiet bus.
    always_comb begin
        sram_w_en       = '0;
        sram_address    = '0;
        sram_write_data = '0;
        if (dm_gnt) begin
            sram_address    = dm_addr;
            sram_write_data = dm_wdata;
            sram_w_en       = dm_we_legal ? dm_we : 4'b0000;
        end else if (if_gnt) begin
            sram_address    = if_addr;
        end
    end

    // Starvation counter, response registers and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            if_rdata  <= '0;
            if_rvalid <= 1'b0;
            dm_rdata  <= '0;
            dm_rvalid <= 1'b0;
            dm_err    <= 1'b0;
        end else begin
            if (!if_req || if_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            if_rvalid <= if_gnt;
            if (if_gnt) begin
                if_rdata <= sram_read_data;
            end

            dm_rvalid <= dm_gnt & dm_read;
            if (dm_gnt && dm_read) begin
                dm_rdata <= sram_read_data;
            end

            if (dm_gnt && !dm_we_legal) begin
                dm_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed, table-driven bench for sram_port_arbiter with a behavioural
// 64 KiB byte SRAM (combinational read, posedge byte-enabled write, wrap).
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        dm_err;
    logic [3:0]  sram_w_en;
    logic [15:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;

    int n_cmp  = 0;
    int n_fail = 0;

    sram_port_arbiter #(.MAX_WAIT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_gnt          (if_gnt),
        .if_rdata        (if_rdata),
        .if_rvalid       (if_rvalid),
        .dm_req          (dm_req),
        .dm_we           (dm_we),
        .dm_addr         (dm_addr),
        .dm_wdata        (dm_wdata),
        .dm_gnt          (dm_gnt),
        .dm_rdata        (dm_rdata),
        .dm_rvalid       (dm_rvalid),
        .dm_err          (dm_err),
        .sram_w_en       (sram_w_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM; contents are loaded once during the first reset.
    logic [7:0] mem [65536];
    logic       mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (rst && !mem_loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[16'h0010] <= 8'h11;
            mem[16'h0011] <= 8'h22;
            mem[16'h0012] <= 8'h33;
            mem[16'h0013] <= 8'h44;
            mem[16'h0200] <= 8'h55;
            mem[16'h0201] <= 8'h66;
            mem[16'h0202] <= 8'h77;
            mem[16'h0203] <= 8'h88;
            mem_loaded    <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sram_w_en[i])
                    mem[16'(sram_address + 16'(i))] <= sram_write_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        sram_read_data = {mem[16'(sram_address + 16'd3)], mem[16'(sram_address + 16'd2)],
                          mem[16'(sram_address + 16'd1)], mem[sram_address]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                         input logic [3:0] we, input logic [15:0] da, input logic [31:0] wd);
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = we;
        dm_addr  = da;
        dm_wdata = wd;
    endtask

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        dm_req;
        logic [3:0]  dm_we;
        logic [15:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        e_if_gnt;
        logic        e_dm_gnt;
        logic [3:0]  e_w_en;
        logic [15:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifv;
        logic [31:0] e_if_rdata;
        logic        e_dmv;
        logic [31:0] e_dm_rdata;
        logic        e_err;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    initial begin
        // inputs: if_req if_addr dm_req dm_we dm_addr dm_wdata
        // expect: if_gnt dm_gnt w_en addr wdata | ifv if_rdata dmv dm_rdata err
        vt[0]  = '{1'b1, 16'h0010, 1'b0, 4'h0, 16'h1234, 32'h0,
                   1'b1, 1'b0, 4'h0, 16'h0010, 32'h0,        1'b1, 32'h44332211, 1'b0, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 16'h0000, 1'b0, 4'hF, 16'hABCD, 32'h5555_5555,
                   1'b0, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b0, 32'h44332211, 1'b0, 32'h0,        1'b0};
        vt[2]  = '{1'b0, 16'h0000, 1'b1, 4'hF, 16'h0100, 32'hDEADBEEF,
                   1'b0, 1'b1, 4'hF, 16'h0100, 32'hDEADBEEF, 1'b0, 32'h44332211, 1'b0, 32'h0,        1'b0};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 4'h1, 16'h0100, 32'h000000AA,
                   1'b0, 1'b1, 4'h1, 16'h0100, 32'h000000AA, 1'b0, 32'h44332211, 1'b0, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 16'h0000, 1'b1, 4'h0, 16'h0100, 32'h0,
                   1'b0, 1'b1, 4'h0, 16'h0100, 32'h0,        1'b0, 32'h44332211, 1'b1, 32'hDEADBEAA, 1'b0};
        vt[5]  = '{1'b0, 16'h0000, 1'b1, 4'h3, 16'h0104, 32'h0000BEEF,
                   1'b0, 1'b1, 4'h3, 16'h0104, 32'h0000BEEF, 1'b0, 32'h44332211, 1'b0, 32'hDEADBEAA, 1'b0};
        vt[6]  = '{1'b0, 16'h0000, 1'b1, 4'h0, 16'h0104, 32'h0,
                   1'b0, 1'b1, 4'h0, 16'h0104, 32'h0,        1'b0, 32'h44332211, 1'b1, 32'h0000BEEF, 1'b0};
        vt[7]  = '{1'b1, 16'h0100, 1'b1, 4'h0, 16'h0010, 32'h0,
                   1'b0, 1'b1, 4'h0, 16'h0010, 32'h0,        1'b0, 32'h44332211, 1'b1, 32'h44332211, 1'b0};
        vt[8]  = '{1'b1, 16'h0100, 1'b0, 4'hF, 16'h0300, 32'h12345678,
                   1'b1, 1'b0, 4'h0, 16'h0100, 32'h0,        1'b1, 32'hDEADBEAA, 1'b0, 32'h44332211, 1'b0};
        vt[9]  = '{1'b0, 16'h0000, 1'b1, 4'h5, 16'h0200, 32'hFFFFFFFF,
                   1'b0, 1'b1, 4'h0, 16'h0200, 32'hFFFFFFFF, 1'b0, 32'hDEADBEAA, 1'b0, 32'h44332211, 1'b1};
        vt[10] = '{1'b0, 16'h0000, 1'b1, 4'h0, 16'h0200, 32'h0,
                   1'b0, 1'b1, 4'h0, 16'h0200, 32'h0,        1'b0, 32'hDEADBEAA, 1'b1, 32'h88776655, 1'b1};
        vt[11] = '{1'b0, 16'h0000, 1'b1, 4'hF, 16'hFFFE, 32'h11223344,
                   1'b0, 1'b1, 4'hF, 16'hFFFE, 32'h11223344, 1'b0, 32'hDEADBEAA, 1'b0, 32'h88776655, 1'b1};
        vt[12] = '{1'b1, 16'h0000, 1'b0, 4'h0, 16'h0000, 32'h0,
                   1'b1, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b1, 32'h00001122, 1'b0, 32'h88776655, 1'b1};
        vt[13] = '{1'b0, 16'h0000, 1'b1, 4'h0, 16'hFFFE, 32'h0,
                   1'b0, 1'b1, 4'h0, 16'hFFFE, 32'h0,        1'b0, 32'h00001122, 1'b1, 32'h11223344, 1'b1};
        vt[14] = '{1'b0, 16'h0000, 1'b1, 4'h8, 16'h0010, 32'hFFFFFFFF,
                   1'b0, 1'b1, 4'h0, 16'h0010, 32'hFFFFFFFF, 1'b0, 32'h00001122, 1'b0, 32'h11223344, 1'b1};
        vt[15] = '{1'b1, 16'h0010, 1'b0, 4'h0, 16'h0000, 32'h0,
                   1'b1, 1'b0, 4'h0, 16'h0010, 32'h0,        1'b1, 32'h44332211, 1'b0, 32'h11223344, 1'b1};

        // Reset with both requesters asserting: no grants, quiet SRAM bus.
        rst = 1'b1;
        drive(1'b1, 16'h0010, 1'b1, 4'hF, 16'h0100, 32'hFFFFFFFF);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #2;
            check("rst if_gnt", 32'(if_gnt), 32'd0);
            check("rst dm_gnt", 32'(dm_gnt), 32'd0);
            check("rst w_en", 32'(sram_w_en), 32'd0);
            @(posedge clk);
            #1;
            check("rst if_rvalid", 32'(if_rvalid), 32'd0);
            check("rst dm_rvalid", 32'(dm_rvalid), 32'd0);
            check("rst if_rdata", if_rdata, 32'd0);
            check("rst dm_rdata", dm_rdata, 32'd0);
            check("rst dm_err", 32'(dm_err), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table: one row per cycle.
        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            drive(vt[i].if_req, vt[i].if_addr, vt[i].dm_req, vt[i].dm_we, vt[i].dm_addr, vt[i].dm_wdata);
            #2;
            check($sformatf("row%0d if_gnt", i), 32'(if_gnt), 32'(vt[i].e_if_gnt));
            check($sformatf("row%0d dm_gnt", i), 32'(dm_gnt), 32'(vt[i].e_dm_gnt));
            check($sformatf("row%0d w_en", i), 32'(sram_w_en), 32'(vt[i].e_w_en));
            check($sformatf("row%0d addr", i), 32'(sram_address), 32'(vt[i].e_addr));
            check($sformatf("row%0d wdata", i), sram_write_data, vt[i].e_wdata);
            @(posedge clk);
            #1;
            check($sformatf("row%0d if_rvalid", i), 32'(if_rvalid), 32'(vt[i].e_ifv));
            check($sformatf("row%0d if_rdata", i), if_rdata, vt[i].e_if_rdata);
            check($sformatf("row%0d dm_rvalid", i), 32'(dm_rvalid), 32'(vt[i].e_dmv));
            check($sformatf("row%0d dm_rdata", i), dm_rdata, vt[i].e_dm_rdata);
            check($sformatf("row%0d dm_err", i), 32'(dm_err), 32'(vt[i].e_err));
        end

        // Contention: both held high; IF forced through every fifth cycle.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drive(1'b1, 16'h0010, 1'b1, 4'h0, 16'h0200, 32'h0);
            #2;
            check($sformatf("cont%0d if_gnt", c), 32'(if_gnt), 32'((c % 5) == 4));
            check($sformatf("cont%0d dm_gnt", c), 32'(dm_gnt), 32'((c % 5) != 4));
            check($sformatf("cont%0d addr", c), 32'(sram_address),
                  ((c % 5) == 4) ? 32'h0010 : 32'h0200);
            @(posedge clk);
            #1;
            check($sformatf("cont%0d if_rvalid", c), 32'(if_rvalid), 32'((c % 5) == 4));
        end

        // Idle clears the wait counter, then build it up to 4 before reset.
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, 16'h0010, 1'b1, 4'h0, 16'h0200, 32'h0);
            #2;
            check($sformatf("prerst%0d dm_gnt", c), 32'(dm_gnt), 32'd1);
        end
        // Reset in the cycle after a DM read grant drops its response.
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("midrst if_gnt", 32'(if_gnt), 32'd0);
        check("midrst dm_gnt", 32'(dm_gnt), 32'd0);
        check("midrst w_en", 32'(sram_w_en), 32'd0);
        @(posedge clk);
        #1;
        check("midrst dm_rvalid", 32'(dm_rvalid), 32'd0);
        check("midrst if_rvalid", 32'(if_rvalid), 32'd0);
        check("midrst dm_rdata", dm_rdata, 32'd0);
        check("midrst dm_err", 32'(dm_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // A fresh count means DM wins four times before IF is forced.
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            #2;
            check($sformatf("postrst%0d if_gnt", c), 32'(if_gnt), 32'(c == 4));
            check($sformatf("postrst%0d dm_gnt", c), 32'(dm_gnt), 32'(c != 4));
            @(posedge clk);
            #1;
            check($sformatf("postrst%0d dm_err", c), 32'(dm_err), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-ported byte-addressed SRAM (64 KiB, 16-bit address, 32-bit little-endian word at address..address+3, combinational read, posedge write) between two requesters: instruction fetch (IF, read-only) and data memory (DM, read/write).
- Grants at most one access per cycle and registers read data with a one-cycle response.
- Fixed priority to DM, with a starvation guard that forces an IF grant after bounded waiting.
- Sits between the core's IF/MEM stages and the SRAM instance.

Parameters:
- MAX_WAIT, 4, number of consecutive cycles IF may be denied while requesting before IF gets forced priority (legal range 1..15).

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- if_req  in  1  IF access request, held high until if_gnt
- if_addr  in  16  IF byte address
- if_gnt  out  1  IF granted this cycle (combinational)
- if_rdata  out  32  registered IF read word
- if_rvalid  out  1  if_rdata valid, single-cycle pulse
- dm_req  in  1  DM access request, held high until dm_gnt
- dm_we  in  4  DM byte-write strobe: 0000 read, 0001 byte, 0011 half, 1111 word
- dm_addr  in  16  DM byte address
- dm_wdata  in  32  DM write data, low-aligned
- dm_gnt  out  1  DM granted this cycle (combinational)
- dm_rdata  out  32  registered DM read word
- dm_rvalid  out  1  dm_rdata valid, single-cycle pulse, reads only
- dm_err  out  1  sticky illegal-strobe flag
- sram_w_en  out  4  to SRAM w_en
- sram_address  out  16  to SRAM address
- sram_write_data  out  32  to SRAM write_data
- sram_read_data  in  32  from SRAM read_data

Behaviour:
- Reset: while rst=1, if_gnt=dm_gnt=0 and sram_w_en=0000. On the first posedge with rst=1, clear if_rdata, dm_rdata, if_rvalid, dm_rvalid, dm_err and wait_cnt. Reset mid-transaction drops the pending response; no rvalid follows.
- Arbitration, combinational, one grant max:
  - force_if = (wait_cnt == MAX_WAIT).
  - dm_gnt = dm_req & ~rst & ~(if_req & force_if).
  - if_gnt = if_req & ~rst & ~dm_gnt.
- wait_cnt (clog2-sized, saturating): clear when if_req=0 or if_gnt=1; increment when if_req=1 and if_gnt=0; never exceeds MAX_WAIT.
- SRAM mux:
  - dm_gnt: sram_address=dm_addr, sram_write_data=dm_wdata, sram_w_en=dm_we if legal else 0000.
  - if_gnt: sram_address=if_addr, sram_w_en=0000, sram_write_data=0.
  - Idle: address 0, w_en 0000, write_data 0.
- Legal dm_we values are 0000, 0001, 0011 and 1111. Any other value still grants and consumes the request, writes nothing, gives no dm_rvalid, and sets dm_err (stays 1 until rst).
- Read latency is 1 cycle. At the posedge ending a grant cycle:
  - IF grant: if_rdata <= sram_read_data, if_rvalid <= 1.
  - DM read grant: dm_rdata <= sram_read_data, dm_rvalid <= 1.
  - rvalid is 0 in every cycle not following such a grant.
  - rdata holds its last value between responses.
- DM writes complete at the posedge ending the grant cycle and produce no response.
- Read-after-write: a read granted in any later cycle returns the written data. A write and a read never share a cycle.
- Back-to-back requests are allowed: a requester may keep req high after gnt for a new request next cycle, achieving 1 access/cycle.
- Address wrap (addr+3 > FFFF) is passed through unchanged; the SRAM wraps.
- No combinational path from sram_read_data to any output.

Test Plan:
- Reset then IF-only reads: preload mem[0x0010..0x0013]=11,22,33,44; if_req=1, if_addr=0x0010 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x44332211; dm_rvalid=0.
- DM write/read: word write dm_we=1111, addr 0x0100, data 0xDEADBEEF -> no dm_rvalid. Byte write 0001, data 0x000000AA. Then read -> dm_rvalid=1 next cycle, dm_rdata=0xDEADBEAA.
- Contention and starvation, MAX_WAIT=4: if_req and dm_req held high continuously -> dm_gnt cycles 0-3, if_gnt cycle 4, dm_gnt cycles 5-8, if_gnt cycle 9 (pattern repeats); never both grants in one cycle.
- Illegal strobe: dm_we=0101, addr 0x0200 -> dm_gnt=1, sram_w_en=0000, mem unchanged, no dm_rvalid, dm_err=1 and stays 1 through later legal accesses until rst.
- Reset mid-operation: grant a DM read, assert rst on the next posedge -> dm_rvalid=0, gnts=0, wait_cnt=0, dm_err=0.
- Wrap: word write 0x11223344 at 0xFFFE -> mem[FFFE]=44, mem[FFFF]=33, mem[0000]=22, mem[0001]=11; IF read at 0x0000 returns 0xXXXX1122 upper bytes from mem[0002..0003].
